mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 64x16 synchronous data memory between two requesters.
- Port 0 is the CPU datapath; port 1 is the switch/button-driven debug/IO access path.
- Serialises their accesses with a round-robin arbiter and sequences each access through a fixed three-phase FSM.
- Sits inside top, between the requesters and the memory instance.

Parameters:
ADDR_WIDTH, 6, memory word-address width
DATA_WIDTH, 16, memory word width

Ports:
clk  in  1  system clock; one clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
m0_req  in  1  port 0 request; held with m0_we/m0_addr/m0_wdata stable until m0_ack
m0_we  in  1  port 0 write enable (1=write, 0=read)
m0_addr  in  ADDR_WIDTH  port 0 address
m0_wdata  in  DATA_WIDTH  port 0 write data
m0_ack  out  1  port 0 one-cycle completion pulse
m0_rdata  out  DATA_WIDTH  port 0 read data, valid while m0_ack=1, held afterwards
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as port 0, for port 1
mem_addr  out  ADDR_WIDTH  memory address
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_WIDTH  memory write data
mem_q  in  DATA_WIDTH  memory read data; 1-cycle synchronous read
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset values, asynchronous: state=IDLE; m0_ack/m1_ack=0; m0_rdata/m1_rdata=0; mem_addr=0; mem_we=0; mem_wdata=0; priority pointer=port 0; busy=0. All outputs are registered.
- FSM states: IDLE, ACCESS, RESP. One transaction takes 3 cycles.
- Request mask: a port's req is ignored in any cycle where that port's ack=1. A requester therefore never needs to drop req combinationally.
- IDLE:
  - Compute the eligible set = req AND NOT ack for each port.
  - If the set is empty, stay in IDLE.
  - Otherwise choose the winner: if only one port is eligible it wins; if both are eligible, the priority-pointer port wins.
  - Register sel=winner and load mem_addr, mem_wdata and the write flag from the winner.
  - Set mem_we=winner's we and go to ACCESS.
- ACCESS:
  - mem_addr/mem_we/mem_wdata are stable; the memory samples them at the end of this cycle.
  - Clear mem_we on exit, so mem_we is high for exactly one cycle.
  - Go to RESP.
- RESP:
  - mem_q is valid.
  - On exit, pulse ack[sel]=1 for one cycle.
  - Reads: rdata[sel]<=mem_q. Writes: rdata is unchanged.
  - Set pointer = other port (not sel), then go to IDLE.
- Latency: req sampled in IDLE at cycle N -> ack high in cycle N+3.
  - Back-to-back: a different port's pending req is granted in the same cycle the previous ack is high, so the next ack arrives in cycle N+6.
  - Same-port repeat: req in cycle N+4 -> ack in cycle N+7.
- Fairness: with both ports continuously requesting, grants strictly alternate.
- Withdrawal: dropping req before it is latched is allowed and harmless. Once latched, the transaction always completes and acks.
- mem_addr/mem_wdata hold their last value in IDLE; only mem_we gates writes.
- Reset mid-transaction: immediate return to IDLE and no ack is issued. If mem_we was high it drops asynchronously, and the write may or may not land.
- No width arithmetic: addresses pass through unchanged. Unused address bits are not permitted (exact ADDR_WIDTH).

Decomposition:
- Shared package mem_arb_pkg: state enum {IDLE, ACCESS, RESP}; port index constants PORT_CPU=0, PORT_DBG=1; NUM_PORTS=2.
- One natural sub-module: rr_arbiter2. It takes the 2-bit eligible vector and the pointer, and returns the winner index and grant_valid; it is purely combinational.
- The FSM, latches and pointer update stay in mem_port_arbiter.

Test Plan:
- Single read: memory preloaded with [5]=16'hBEEF; m0 read addr 5 at cycle 0 -> mem_we stays 0; m0_ack=1 in cycle 3 only; m0_rdata=16'hBEEF; m1_ack stays 0.
- Write then read: m1 writes 16'h1234 to addr 63 -> mem_we=1 for exactly one cycle with mem_addr=63; m1_ack at +3; a subsequent m1 read of 63 returns 16'h1234.
- Contention: m0 and m1 both request from cycle 0 after reset (pointer=0) -> m0_ack at cycle 3, m1_ack at cycle 6. Both held continuously -> acks alternate m0, m1, m0, m1.
- Held req after ack: m0 keeps req high through its ack cycle, then drops it -> exactly one m0 transaction; busy=0 afterwards.
- Reset mid-access: assert rst during ACCESS -> state IDLE and mem_we=0 immediately; no ack; pointer=0; all rdata=0.
- Withdrawal: m1 pulses req for one cycle while the arbiter is busy serving m0 -> m1 is never granted; m1_ack stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   state_t   : transaction sequencer states (IDLE -> ACCESS -> RESP)
//   PORT_CPU  : index of the CPU datapath requester
//   PORT_DBG  : index of the switch/button debug/IO requester
//   NUM_PORTS : number of requesters sharing the memory
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned PORT_CPU  = 0;
  localparam int unsigned PORT_DBG  = 1;
  localparam int unsigned NUM_PORTS = 2;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin grant selection (purely combinational).
//   i_eligible    : per-port eligible bits (req and not currently acked)
//   i_ptr         : priority port, wins when both are eligible
//   o_winner      : index of the granted port
//   o_grant_valid : at least one port is eligible
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_eligible,
  input  logic                 i_ptr,
  output logic                 o_winner,
  output logic                 o_grant_valid
);

  always_comb begin
    o_grant_valid = |i_eligible;
    o_winner      = 1'b0;
    if (i_eligible[PORT_CPU] && i_eligible[PORT_DBG]) begin
      o_winner = i_ptr;
    end else if (i_eligible[PORT_DBG]) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous data memory between the CPU (port 0)
// and the debug/IO path (port 1). Each access runs IDLE -> ACCESS -> RESP
// and is completed by a one-cycle ack pulse to the owning port.
//   clk, rst             : clock, asynchronous active-high reset
//   m0_* / m1_*          : requester ports (req/we/addr/wdata in, ack/rdata out)
//   mem_addr/we/wdata    : registered memory controls
//   mem_q                : memory read data (one-cycle synchronous read)
//   busy                 : high while in ACCESS or RESP
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  state_t                r_state, w_state_nxt;
  logic                  r_sel, w_sel_nxt;
  logic                  r_ptr, w_ptr_nxt;
  logic                  r_wr, w_wr_nxt;
  logic [NUM_PORTS-1:0]  r_ack, w_ack_nxt;
  logic [DATA_WIDTH-1:0] r_rdata0, w_rdata0_nxt;
  logic [DATA_WIDTH-1:0] r_rdata1, w_rdata1_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic                  r_busy;

  logic [NUM_PORTS-1:0]  w_eligible;
  logic                  w_winner;
  logic                  w_grant_valid;

  // A port being acked this cycle is masked, so a held req is not re-granted.
  assign w_eligible = {m1_req & ~r_ack[PORT_DBG], m0_req & ~r_ack[PORT_CPU]};

  rr_arbiter2 u_rr (
    .i_eligible    (w_eligible),
    .i_ptr         (r_ptr),
    .o_winner      (w_winner),
    .o_grant_valid (w_grant_valid)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_ptr_nxt       = r_ptr;
    w_wr_nxt        = r_wr;
    w_ack_nxt       = '0;
    w_rdata0_nxt    = r_rdata0;
    w_rdata1_nxt    = r_rdata1;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_sel_nxt       = w_winner;
          w_wr_nxt        = w_winner ? m1_we : m0_we;
          w_mem_we_nxt    = w_winner ? m1_we : m0_we;
          w_mem_addr_nxt  = w_winner ? m1_addr : m0_addr;
          w_mem_wdata_nxt = w_winner ? m1_wdata : m0_wdata;
          w_state_nxt     = ACCESS;
        end
      end
      ACCESS: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        w_ack_nxt[r_sel] = 1'b1;
        if (!r_wr) begin
          if (r_sel) w_rdata1_nxt = mem_q;
          else       w_rdata0_nxt = mem_q;
        end
        w_ptr_nxt   = ~r_sel;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_ptr       <= 1'b0;
      r_wr        <= 1'b0;
      r_ack       <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wr        <= w_wr_nxt;
      r_ack       <= w_ack_nxt;
      r_rdata0    <= w_rdata0_nxt;
      r_rdata1    <= w_rdata1_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign m0_ack    = r_ack[PORT_CPU];
  assign m1_ack    = r_ack[PORT_DBG];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64x16 memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [5:0]  m0_addr = '0;
  logic [15:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [5:0]  m1_addr = '0;
  logic [15:0] m1_wdata = '0;
  logic        m0_ack, m1_ack, mem_we, busy;
  logic [15:0] m0_rdata, m1_rdata, mem_wdata;
  logic [5:0]  mem_addr;
  logic [15:0] mem_q;

  logic [15:0] mem [64];
  logic        mem_load = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_q(mem_q), .busy(busy)
  );

  // Memory model: word i holds 16'h1000+i, except word 5 = 16'hBEEF.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + i[15:0];
      mem[5] <= 16'hBEEF;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_q <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        m0_req, m0_we;
    logic [5:0]  m0_addr;
    logic [15:0] m0_wdata;
    logic        m1_req, m1_we;
    logic [5:0]  m1_addr;
    logic [15:0] m1_wdata;
    logic        e_a0, e_a1, e_we, e_busy;
    logic [5:0]  e_addr;
    logic [15:0] e_wd, e_rd0, e_rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, w0, input logic [5:0] a0, input logic [15:0] d0,
    input logic r1, w1, input logic [5:0] a1, input logic [15:0] d1,
    input logic ea0, ea1, ewe, ebusy, input logic [5:0] eaddr,
    input logic [15:0] ewd, erd0, erd1);
    vec_t v;
    v.m0_req = r0; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0;
    v.m1_req = r1; v.m1_we = w1; v.m1_addr = a1; v.m1_wdata = d1;
    v.e_a0 = ea0; v.e_a1 = ea1; v.e_we = ewe; v.e_busy = ebusy;
    v.e_addr = eaddr; v.e_wd = ewd; v.e_rd0 = erd0; v.e_rd1 = erd1;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic a0, a1, we, bz,
                         input logic [5:0] ad, input logic [15:0] wd, rd0, rd1);
    chk($sformatf("%s m0_ack", tag), 32'(m0_ack), 32'(a0));
    chk($sformatf("%s m1_ack", tag), 32'(m1_ack), 32'(a1));
    chk($sformatf("%s mem_we", tag), 32'(mem_we), 32'(we));
    chk($sformatf("%s busy", tag), 32'(busy), 32'(bz));
    chk($sformatf("%s mem_addr", tag), 32'(mem_addr), 32'(ad));
    chk($sformatf("%s mem_wdata", tag), 32'(mem_wdata), 32'(wd));
    chk($sformatf("%s m0_rdata", tag), 32'(m0_rdata), 32'(rd0));
    chk($sformatf("%s m1_rdata", tag), 32'(m1_rdata), 32'(rd1));
  endtask

  vec_t tbl[25];

  initial begin
    // Each row: inputs applied before an edge, outputs expected just after it.
    tbl[0]  = mk(1,0, 5,0,      0,0, 0,0,       0,0,0,1, 5,16'h0,   16'h0,   16'h0);
    tbl[1]  = mk(1,0, 5,0,      0,0, 0,0,       0,0,0,1, 5,16'h0,   16'h0,   16'h0);
    tbl[2]  = mk(1,0, 5,0,      0,0, 0,0,       1,0,0,0, 5,16'h0,   16'hBEEF,16'h0);
    tbl[3]  = mk(1,0, 5,0,      0,0, 0,0,       0,0,0,0, 5,16'h0,   16'hBEEF,16'h0);
    tbl[4]  = mk(0,0, 0,0,      1,1,63,16'h1234,0,0,1,1,63,16'h1234,16'hBEEF,16'h0);
    tbl[5]  = mk(0,0, 0,0,      1,1,63,16'h1234,0,0,0,1,63,16'h1234,16'hBEEF,16'h0);
    tbl[6]  = mk(0,0, 0,0,      1,1,63,16'h1234,0,1,0,0,63,16'h1234,16'hBEEF,16'h0);
    tbl[7]  = mk(0,0, 0,0,      1,0,63,0,       0,0,0,0,63,16'h1234,16'hBEEF,16'h0);
    tbl[8]  = mk(0,0, 0,0,      1,0,63,0,       0,0,0,1,63,16'h0,   16'hBEEF,16'h0);
    tbl[9]  = mk(0,0, 0,0,      1,0,63,0,       0,0,0,1,63,16'h0,   16'hBEEF,16'h0);
    tbl[10] = mk(0,0, 0,0,      1,0,63,0,       0,1,0,0,63,16'h0,   16'hBEEF,16'h1234);
    tbl[11] = mk(0,0, 0,0,      0,0, 0,0,       0,0,0,0,63,16'h0,   16'hBEEF,16'h1234);
    tbl[12] = mk(1,0, 1,0,      1,0, 2,0,       0,0,0,1, 1,16'h0,   16'hBEEF,16'h1234);
    tbl[13] = mk(1,0, 1,0,      1,0, 2,0,       0,0,0,1, 1,16'h0,   16'hBEEF,16'h1234);
    tbl[14] = mk(1,0, 1,0,      1,0, 2,0,       1,0,0,0, 1,16'h0,   16'h1001,16'h1234);
    tbl[15] = mk(1,0, 3,0,      1,0, 2,0,       0,0,0,1, 2,16'h0,   16'h1001,16'h1234);
    tbl[16] = mk(1,0, 3,0,      1,0, 2,0,       0,0,0,1, 2,16'h0,   16'h1001,16'h1234);
    tbl[17] = mk(1,0, 3,0,      1,0, 2,0,       0,1,0,0, 2,16'h0,   16'h1001,16'h1002);
    tbl[18] = mk(1,0, 3,0,      1,0, 4,0,       0,0,0,1, 3,16'h0,   16'h1001,16'h1002);
    tbl[19] = mk(1,0, 3,0,      1,0, 4,0,       0,0,0,1, 3,16'h0,   16'h1001,16'h1002);
    tbl[20] = mk(1,0, 3,0,      1,0, 4,0,       1,0,0,0, 3,16'h0,   16'h1003,16'h1002);
    tbl[21] = mk(1,0, 3,0,      1,0, 4,0,       0,0,0,1, 4,16'h0,   16'h1003,16'h1002);
    tbl[22] = mk(1,0, 3,0,      1,0, 4,0,       0,0,0,1, 4,16'h0,   16'h1003,16'h1002);
    tbl[23] = mk(1,0, 3,0,      1,0, 4,0,       0,1,0,0, 4,16'h0,   16'h1003,16'h1004);
    tbl[24] = mk(0,0, 0,0,      0,0, 0,0,       0,0,0,0, 4,16'h0,   16'h1003,16'h1004);

    // Reset state
    step();
    step();
    chk_all("reset", 0,0,0,0, 6'd0, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    mem_load = 1'b0;

    for (int i = 0; i < 25; i++) begin
      m0_req = tbl[i].m0_req; m0_we = tbl[i].m0_we;
      m0_addr = tbl[i].m0_addr; m0_wdata = tbl[i].m0_wdata;
      m1_req = tbl[i].m1_req; m1_we = tbl[i].m1_we;
      m1_addr = tbl[i].m1_addr; m1_wdata = tbl[i].m1_wdata;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].e_a0, tbl[i].e_a1, tbl[i].e_we,
              tbl[i].e_busy, tbl[i].e_addr, tbl[i].e_wd, tbl[i].e_rd0, tbl[i].e_rd1);
    end

    // m0 read of addr 6 moves the pointer to port 1 before the reset test.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd6;
    step(); step(); step();
    chk("ptrsetup m0_ack", 32'(m0_ack), 32'd1);
    chk("ptrsetup m0_rdata", 32'(m0_rdata), 32'h1006);
    m0_req = 1'b0;
    step();

    // Reset in the middle of a write access.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd10; m0_wdata = 16'h5555;
    step();
    chk("midrst pre mem_we", 32'(mem_we), 32'd1);
    chk("midrst pre busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("midrst", 0,0,0,0, 6'd0, 16'h0, 16'h0, 16'h0);
    step();
    chk_all("midrst held", 0,0,0,0, 6'd0, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0;

    // Both request after reset: pointer is back on port 0, so m0 wins.
    m0_req = 1'b1; m0_addr = 6'd7;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd8;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("postrst c%0d m1_ack", k), 32'(m1_ack), 32'd0);
      chk($sformatf("postrst c%0d m0_ack", k), 32'(m0_ack), (k == 2) ? 32'd1 : 32'd0);
    end
    chk("postrst m0_rdata", 32'(m0_rdata), 32'h1007);
    chk("postrst mem_addr", 32'(mem_addr), 32'd7);
    // m1 drops its request before it was ever latched.
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    chk("postrst idle busy", 32'(busy), 32'd0);

    // m1 pulses req for one cycle while m0 is being served.
    m0_req = 1'b1; m0_addr = 6'd9;
    step();
    chk("wd access busy", 32'(busy), 32'd1);
    m1_req = 1'b1; m1_addr = 6'd11;
    step();
    m1_req = 1'b0;
    step();
    chk("wd m0_ack", 32'(m0_ack), 32'd1);
    chk("wd m1_ack", 32'(m1_ack), 32'd0);
    chk("wd m0_rdata", 32'(m0_rdata), 32'h1009);
    m0_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("wd after c%0d m1_ack", k), 32'(m1_ack), 32'd0);
      chk($sformatf("wd after c%0d busy", k), 32'(busy), 32'd0);
    end
    chk("wd m1_rdata", 32'(m1_rdata), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
